// File: rtl/rocc_cmd_buffer_pkg.sv
// Shared types for the RoCC command buffer: issue-side operand bundle, the
// command presented to the RoCC unit, and the RoCC response word.
package rocc_cmd_buffer_pkg;

  localparam int unsigned ROCC_CMD_DEPTH     = 4;
  localparam int unsigned ROCC_TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [63:0]                   operand_a;
    logic [63:0]                   operand_b;
    logic [ROCC_TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic [6:0]                    funct7;
    logic [4:0]                    rd;
    logic                          xd;
    logic [63:0]                   rs1;
    logic [63:0]                   rs2;
    logic [ROCC_TRANS_ID_BITS-1:0] trans_id;
  } rocc_cmd_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } rocc_data_t;

  function automatic rocc_cmd_t build_cmd(input fu_data_t fu, input logic [6:0] funct7,
                                          input logic [4:0] rd, input logic xd);
    rocc_cmd_t cmd;
    cmd.funct7   = funct7;
    cmd.rd       = rd;
    cmd.xd       = xd;
    cmd.rs1      = fu.operand_a;
    cmd.rs2      = fu.operand_b;
    cmd.trans_id = fu.trans_id;
    return cmd;
  endfunction

endpackage

// File: rtl/rocc_cmd_buffer_if.sv
// Issue, commit and RoCC-dispatch signals of the command buffer. The master
// side is the pipeline/RoCC environment, the slave side is the buffer itself.
interface rocc_cmd_buffer_if #(
  parameter int unsigned TRANS_ID_BITS = rocc_cmd_buffer_pkg::ROCC_TRANS_ID_BITS
);
  import rocc_cmd_buffer_pkg::*;

  logic                     issue_valid_i;
  logic                     issue_ready_o;
  fu_data_t                 fu_data_i;
  logic [6:0]               rocc_funct7_i;
  logic [4:0]               rocc_rd_i;
  logic                     rocc_xd_i;
  logic                     commit_i;
  logic [TRANS_ID_BITS-1:0] commit_trans_id_i;
  rocc_cmd_t                rocc_cmd_o;
  logic                     rocc_cmd_valid_o;
  logic                     rocc_cmd_ready_i;
  logic                     busy_o;
  logic                     commit_err_o;

  modport master (
    output issue_valid_i, fu_data_i, rocc_funct7_i, rocc_rd_i, rocc_xd_i,
           commit_i, commit_trans_id_i, rocc_cmd_ready_i,
    input  issue_ready_o, rocc_cmd_o, rocc_cmd_valid_o, busy_o, commit_err_o
  );

  modport slave (
    input  issue_valid_i, fu_data_i, rocc_funct7_i, rocc_rd_i, rocc_xd_i,
           commit_i, commit_trans_id_i, rocc_cmd_ready_i,
    output issue_ready_o, rocc_cmd_o, rocc_cmd_valid_o, busy_o, commit_err_o
  );

endinterface

// File: rtl/rocc_cmd_buffer.sv
// In-order RoCC command queue: entries are enqueued speculatively, marked
// committed by the commit stage, and only committed entries are dispatched.
module rocc_cmd_buffer
  import rocc_cmd_buffer_pkg::*;
#(
  parameter int unsigned DEPTH         = ROCC_CMD_DEPTH,
  parameter int unsigned TRANS_ID_BITS = ROCC_TRANS_ID_BITS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  rocc_cmd_buffer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  rocc_cmd_t                mem_r [DEPTH];
  logic [PTR_W-1:0]         wptr_r, cptr_r, rptr_r;
  logic [PTR_W-1:0]         wptr_s, cptr_s, rptr_s;
  logic [CNT_W-1:0]         cnt_r, ccnt_r, cnt_s, ccnt_s;
  logic                     commit_err_r, commit_err_s;
  logic                     enq_s, deq_s, has_unc_s, commit_ok_s;
  logic [TRANS_ID_BITS-1:0] unc_tid_s;

  assign bus.issue_ready_o    = (cnt_r != FULL_CNT);
  assign bus.rocc_cmd_valid_o = (ccnt_r != ZERO_CNT);
  assign bus.rocc_cmd_o       = mem_r[rptr_r];
  assign bus.busy_o           = (cnt_r != ZERO_CNT);
  assign bus.commit_err_o     = commit_err_r;

  // Next-state for pointers and counters; flush truncates after commit/dispatch.
  always_comb begin
    enq_s        = bus.issue_valid_i && (cnt_r != FULL_CNT) && !flush_i;
    deq_s        = (ccnt_r != ZERO_CNT) && bus.rocc_cmd_ready_i;
    has_unc_s    = (cnt_r > ccnt_r);
    commit_ok_s  = bus.commit_i && has_unc_s;
    unc_tid_s    = mem_r[cptr_r].trans_id;
    commit_err_s = bus.commit_i && (!has_unc_s || (bus.commit_trans_id_i != unc_tid_s));
    cptr_s       = cptr_r + PTR_W'(commit_ok_s);
    rptr_s       = rptr_r + PTR_W'(deq_s);
    ccnt_s       = ccnt_r + CNT_W'(commit_ok_s) - CNT_W'(deq_s);
    if (flush_i) begin
      wptr_s = cptr_s;
      cnt_s  = ccnt_s;
    end else begin
      wptr_s = wptr_r + PTR_W'(enq_s);
      cnt_s  = cnt_r + CNT_W'(enq_s) - CNT_W'(deq_s);
    end
  end

  // Pointer, counter and error-pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_r       <= {PTR_W{1'b0}};
      cptr_r       <= {PTR_W{1'b0}};
      rptr_r       <= {PTR_W{1'b0}};
      cnt_r        <= ZERO_CNT;
      ccnt_r       <= ZERO_CNT;
      commit_err_r <= 1'b0;
    end else begin
      wptr_r       <= wptr_s;
      cptr_r       <= cptr_s;
      rptr_r       <= rptr_s;
      cnt_r        <= cnt_s;
      ccnt_r       <= ccnt_s;
      commit_err_r <= commit_err_s;
    end
  end

  // Entry storage; never reset since the counters say which slots are live.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[wptr_r] <= build_cmd(bus.fu_data_i, bus.rocc_funct7_i, bus.rocc_rd_i, bus.rocc_xd_i);
    end
  end

endmodule

// File: tb/tb_rocc_cmd_buffer.sv
// Directed bench for rocc_cmd_buffer with a queue-based reference model of
// uncommitted and committed-but-undispatched entries.
module tb_rocc_cmd_buffer;
  import rocc_cmd_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  rocc_cmd_buffer_if bus ();

  rocc_cmd_buffer #(.DEPTH(4), .TRANS_ID_BITS(3)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_commit = 0;
  int n_disp = 0;
  rocc_cmd_t pend_q[$];
  rocc_cmd_t exp_q[$];
  rocc_cmd_t nul = '0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic rocc_cmd_t mk(input logic [6:0] f7, input logic [4:0] rd, input logic xd,
                                   input logic [63:0] a, input logic [63:0] b, input logic [2:0] tid);
    rocc_cmd_t c;
    c.funct7 = f7; c.rd = rd; c.xd = xd; c.rs1 = a; c.rs2 = b; c.trans_id = tid;
    return c;
  endfunction

  function automatic rocc_cmd_t mkr(input int tid);
    return mk(7'($urandom), 5'($urandom), 1'($urandom), {$urandom(), $urandom()},
              {$urandom(), $urandom()}, 3'(tid));
  endfunction

  // Dispatch monitor: a handshake seen before the edge retires the oldest committed entry.
  always @(negedge clk) begin
    if (!rst && bus.rocc_cmd_valid_o && bus.rocc_cmd_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL dispatch_unexpected: observed cmd %0h expected none", bus.rocc_cmd_o);
      end else begin
        chk("dispatch_cmd", 160'(bus.rocc_cmd_o), 160'(exp_q.pop_front()));
        n_disp++;
      end
    end
  end

  task automatic check_state();
    chk("busy", 160'(bus.busy_o), 160'((pend_q.size() + exp_q.size()) != 0));
    chk("valid", 160'(bus.rocc_cmd_valid_o), 160'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("head_cmd", 160'(bus.rocc_cmd_o), 160'(exp_q[0]));
  endtask

  task automatic step(input logic iv, input rocc_cmd_t e, input logic cm, input logic [2:0] ctid,
                      input logic fl, input logic rdy);
    logic m_ready, m_err;
    m_ready = (pend_q.size() + exp_q.size()) != 4;
    if (iv) chk("issue_ready", 160'(bus.issue_ready_o), 160'(m_ready));
    bus.issue_valid_i        = iv;
    bus.fu_data_i.operand_a  = e.rs1;
    bus.fu_data_i.operand_b  = e.rs2;
    bus.fu_data_i.trans_id   = e.trans_id;
    bus.rocc_funct7_i        = e.funct7;
    bus.rocc_rd_i            = e.rd;
    bus.rocc_xd_i            = e.xd;
    bus.commit_i             = cm;
    bus.commit_trans_id_i    = ctid;
    bus.rocc_cmd_ready_i     = rdy;
    flush                    = fl;
    m_err = 1'b0;
    if (cm) begin
      if (pend_q.size() == 0) m_err = 1'b1;
      else begin
        m_err = (pend_q[0].trans_id != ctid);
        exp_q.push_back(pend_q.pop_front());
        n_commit++;
      end
    end
    if (fl) pend_q.delete();
    if (iv && m_ready && !fl) pend_q.push_back(e);
    @(posedge clk); #1;
    bus.issue_valid_i = 1'b0;
    bus.commit_i      = 1'b0;
    flush             = 1'b0;
    chk("commit_err", 160'(bus.commit_err_o), 160'(m_err));
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rocc_cmd_ready_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    n_commit -= exp_q.size();
    pend_q.delete();
    exp_q.delete();
    chk("rst_issue_ready", 160'(bus.issue_ready_o), 160'(1'b1));
    chk("rst_commit_err", 160'(bus.commit_err_o), 160'(1'b0));
    check_state();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.issue_valid_i = 1'b0;
    bus.fu_data_i = '0;
    bus.rocc_funct7_i = 7'd0;
    bus.rocc_rd_i = 5'd0;
    bus.rocc_xd_i = 1'b0;
    bus.commit_i = 1'b0;
    bus.commit_trans_id_i = 3'd0;
    bus.rocc_cmd_ready_i = 1'b0;
    do_reset();

    // single entry: not visible before commit, visible the cycle after
    step(1'b1, mk(7'h05, 5'd3, 1'b1, 64'h11, 64'h22, 3'd2), 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, nul, 1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);

    // fill to full, fifth attempt rejected, then commit and drain in order
    for (int i = 0; i < 5; i++) step(1'b1, mkr(i), 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, nul, 1'b1, 3'(i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);

    // commit two of three, flush the third
    for (int i = 0; i < 3; i++) step(1'b1, mkr(i), 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, nul, 1'b1, 3'd0, 1'b0, 1'b0);
    step(1'b0, nul, 1'b1, 3'd1, 1'b0, 1'b0);
    step(1'b0, nul, 1'b0, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);

    // flush + commit + issue in one cycle
    for (int i = 3; i < 6; i++) step(1'b1, mkr(i), 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, mkr(6), 1'b1, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);

    // commit on empty buffer: error pulse, no state change
    step(1'b0, nul, 1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);

    // back-pressure: head held stable, then exactly one dequeue
    step(1'b1, mkr(1), 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, mkr(2), 1'b1, 3'd1, 1'b0, 1'b0);
    step(1'b0, nul, 1'b1, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);

    // trans_id mismatch: error pulse but commit still applies
    step(1'b1, mkr(4), 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, nul, 1'b1, 3'd5, 1'b0, 1'b1);
    step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);

    // reset mid-operation discards committed entries too
    for (int i = 0; i < 3; i++) step(1'b1, mkr(i), 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, nul, 1'b1, 3'd0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);

    // streaming with wrap-around
    for (int i = 0; i <= 10; i++)
      step(i < 10, mkr(i % 8), i > 0, 3'((i + 7) % 8), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, nul, 1'b0, 3'd0, 1'b0, 1'b1);

    chk("dispatch_count", 160'(n_disp), 160'(n_commit));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
